// File: rtl/mbinit_pkg.sv
// Shared definitions for the mainband-init sideband path: arbiter state codes,
// sideband message encodings and a small index-width helper.
package mbinit_pkg;

  typedef logic [1:0] sb_arb_state_t;

  localparam sb_arb_state_t ST_IDLE    = 2'd0;
  localparam sb_arb_state_t ST_GRANT   = 2'd1;
  localparam sb_arb_state_t ST_BUSY    = 2'd2;
  localparam sb_arb_state_t ST_RELEASE = 2'd3;

  localparam logic [3:0] SB_MBINIT_INIT_REQ    = 4'b0001;
  localparam logic [3:0] SB_MBINIT_INIT_RESP   = 4'b0010;
  localparam logic [3:0] SB_MBINIT_RESULT_REQ  = 4'b0011;
  localparam logic [3:0] SB_MBINIT_RESULT_RESP = 4'b0100;
  localparam logic [3:0] SB_MBINIT_DONE_REQ    = 4'b0101;
  localparam logic [3:0] SB_MBINIT_DONE_RESP   = 4'b0110;

  // A single requester still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: first active request at or after ptr_i, wrapping.
// Purely combinational; gnt_o is one-hot (or zero when nothing is requested).
module rr_picker
  import mbinit_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;
  logic             found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      pos = sum[IDX_W-1:0];
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/sb_tx_arbiter.sv
// Arbitrates sideband TX messages from several requesters onto one serializer.
// IDLE -> GRANT (launch strobe) -> BUSY (until done/timeout) -> RELEASE (completion pulse).
module sb_tx_arbiter
  import mbinit_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int SB_MSG_Width = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_REQ-1:0]              i_msg_valid,
  input  logic [NUM_REQ*SB_MSG_Width-1:0] i_encoded_sb_msg,
  input  logic                            i_sb_done,
  input  logic                            i_flush,
  output logic [SB_MSG_Width-1:0]         o_sb_msg,
  output logic                            o_sb_msg_valid,
  output logic [NUM_REQ-1:0]              o_grant,
  output logic                            o_sb_busy,
  output logic [NUM_REQ-1:0]              o_falling_edge_busy,
  output logic                            o_timeout
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  sb_arb_state_t     state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  win_idx_q, win_idx_d;
  logic [NUM_REQ-1:0] win_oh_q, win_oh_d;
  logic [SB_MSG_Width-1:0] msg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              expire;
  logic              timeout_d;
  logic              busy_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [NUM_REQ-1:0] fe_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req_i (i_msg_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  // Expiry is judged on the count this cycle would reach.
  assign expire  = ({1'b0, cnt_q} + 1'b1) >= (CNT_W+1)'(TIMEOUT_CYC);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_idx_d = win_idx_q;
    win_oh_d  = win_oh_q;
    msg_d     = o_sb_msg;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|i_msg_valid) begin
          state_d   = ST_GRANT;
          win_idx_d = pick_idx;
          win_oh_d  = pick_gnt;
          msg_d     = i_encoded_sb_msg[pick_idx*SB_MSG_Width +: SB_MSG_Width];
          cnt_d     = '0;
        end
      end
      ST_GRANT: begin
        state_d = ST_BUSY;
        cnt_d   = cnt_inc;
      end
      ST_BUSY: begin
        cnt_d = cnt_inc;
        if (i_sb_done) begin
          state_d = ST_RELEASE;
        end else if (expire) begin
          state_d   = ST_RELEASE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        rr_ptr_d = (win_idx_q == LAST_IDX) ? '0 : win_idx_q + 1'b1;
      end
    endcase

    if (i_flush) begin
      state_d   = ST_IDLE;
      rr_ptr_d  = rr_ptr_q;
      timeout_d = 1'b0;
    end

    busy_d  = (state_d == ST_GRANT) || (state_d == ST_BUSY);
    grant_d = busy_d ? win_oh_d : '0;
    fe_d    = (state_d == ST_RELEASE) ? win_oh_d : '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q             <= ST_IDLE;
      rr_ptr_q            <= '0;
      win_idx_q           <= '0;
      win_oh_q            <= '0;
      cnt_q               <= '0;
      o_sb_msg            <= '0;
      o_sb_msg_valid      <= 1'b0;
      o_grant             <= '0;
      o_sb_busy           <= 1'b0;
      o_falling_edge_busy <= '0;
      o_timeout           <= 1'b0;
    end else begin
      state_q             <= state_d;
      rr_ptr_q            <= rr_ptr_d;
      win_idx_q           <= win_idx_d;
      win_oh_q            <= win_oh_d;
      cnt_q               <= cnt_d;
      o_sb_msg            <= msg_d;
      o_sb_msg_valid      <= (state_d == ST_GRANT);
      o_grant             <= grant_d;
      o_sb_busy           <= busy_d;
      o_falling_edge_busy <= fe_d;
      o_timeout           <= timeout_d;
    end
  end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Bench for sb_tx_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_sb_tx_arbiter;
  import mbinit_pkg::*;

  localparam int N = 3;
  localparam int W = 4;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_v = '0;
  logic [W-1:0] req_msg [N];
  logic [N*W-1:0] enc;
  logic done = 1'b0;
  logic flush = 1'b0;

  logic [W-1:0] sb_msg;
  logic         msg_vld;
  logic [N-1:0] grant;
  logic         busy;
  logic [N-1:0] fe;
  logic         tout;

  always #5 clk = ~clk;

  always_comb begin
    enc = '0;
    for (int k = 0; k < N; k++) enc[k*W +: W] = req_msg[k];
  end

  sb_tx_arbiter #(
    .NUM_REQ      (N),
    .SB_MSG_Width (W),
    .TIMEOUT_CYC  (T)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_msg_valid         (req_v),
    .i_encoded_sb_msg    (enc),
    .i_sb_done           (done),
    .i_flush             (flush),
    .o_sb_msg            (sb_msg),
    .o_sb_msg_valid      (msg_vld),
    .o_grant             (grant),
    .o_sb_busy           (busy),
    .o_falling_edge_busy (fe),
    .o_timeout           (tout)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: who owns the serializer and for how many cycles since launch,
  // plus a pending release notice for the previous owner.
  int         m_owner = -1;
  int         m_age = 0;
  bit         m_rel = 1'b0;
  int         m_rel_owner = 0;
  int         m_ptr = 0;
  bit         m_to = 1'b0;
  logic [W-1:0] m_msg = '0;

  int cyc = 0;
  int busy_seen, fe_seen, to_seen, last_launch, last_to;
  int launch_log[$];
  int launch_cyc[$];

  task automatic clr();
    busy_seen = 0; fe_seen = 0; to_seen = 0; last_launch = 0; last_to = 0;
    launch_log.delete(); launch_cyc.delete();
  endtask

  task automatic model_update();
    bit nxt_to;
    nxt_to = 1'b0;
    if (flush) begin
      m_owner = -1;
      m_rel   = 1'b0;
    end else if (m_rel) begin
      m_rel = 1'b0;
      m_ptr = (m_rel_owner + 1) % N;
    end else if (m_owner >= 0) begin
      if (m_age == 0) begin
        m_age = 1;
      end else if (done || (m_age + 1 >= T)) begin
        nxt_to      = !done;
        m_rel       = 1'b1;
        m_rel_owner = m_owner;
        m_owner     = -1;
      end else begin
        m_age++;
      end
    end else if (req_v != '0) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (req_v[k]) begin
          m_owner = k;
          break;
        end
      end
      m_age = 0;
      m_msg = req_msg[m_owner];
    end
    m_to = nxt_to;
  endtask

  task automatic model_check();
    logic [N-1:0] e_grant, e_fe;
    bit e_vld;
    e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e_fe    = m_rel ? N'(1 << m_rel_owner) : '0;
    e_vld   = (m_owner >= 0) && (m_age == 0);
    cyc++;
    chk("busy", busy, (m_owner >= 0));
    chk("grant", grant, e_grant);
    chk("launch", msg_vld, e_vld);
    chk("fe_pulse", fe, e_fe);
    chk("timeout", tout, m_to);
    if (e_vld) begin
      chk("msg", sb_msg, m_msg);
      launch_log.push_back(m_owner);
      launch_cyc.push_back(cyc);
      last_launch = cyc;
    end
    if (m_to) last_to = cyc;
    busy_seen += int'(busy);
    fe_seen   += int'(fe != '0);
    to_seen   += int'(tout);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_check();
    // Requesters drop their level request once they see completion.
    for (int k = 0; k < N; k++) if (m_rel && m_rel_owner == k) req_v[k] = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_vld"}, msg_vld, 0);
    chk({tag, "_fe"}, fe, 0);
    chk({tag, "_to"}, tout, 0);
    chk({tag, "_msg"}, sb_msg, 0);
  endtask

  initial begin
    for (int k = 0; k < N; k++) req_msg[k] = '0;

    // Reset state
    @(negedge clk);
    chk_all_zero("rst");
    req_v = 3'b011;
    @(negedge clk);
    chk_all_zero("rst_req");
    req_v = '0;
    rst = 1'b0;

    // Single request, done 5 cycles after launch
    clr();
    req_msg[0] = SB_MBINIT_INIT_REQ;
    req_v = 3'b001;
    cycle();
    repeat (5) cycle();
    done = 1'b1;
    cycle();
    done = 1'b0;
    repeat (2) cycle();
    chk("A_busy_len", busy_seen, 6);
    chk("A_fe_cnt", fe_seen, 1);
    chk("A_launches", launch_log.size(), 1);

    // Timeout with no done
    clr();
    req_msg[1] = SB_MBINIT_RESULT_REQ;
    req_v = 3'b010;
    repeat (11) cycle();
    chk("C_to_cnt", to_seen, 1);
    chk("C_to_gap", last_to - last_launch, T);
    chk("C_fe_cnt", fe_seen, 1);

    // Flush three cycles into BUSY; pointer must stay on requester 2
    clr();
    req_msg[2] = SB_MBINIT_DONE_REQ;
    req_v = 3'b100;
    repeat (4) cycle();
    flush = 1'b1;
    req_v[0] = 1'b1;
    cycle();
    flush = 1'b0;
    chk("D_busy", busy, 0);
    chk("D_fe_cnt", fe_seen, 0);
    cycle();
    chk("D_regrant", launch_log[launch_log.size()-1], 2);
    done = 1'b1;
    repeat (9) cycle();
    done = 1'b0;

    // done coincident with timer expiry
    clr();
    req_msg[0] = SB_MBINIT_INIT_RESP;
    req_v = 3'b001;
    repeat (8) cycle();
    done = 1'b1;
    cycle();
    done = 1'b0;
    repeat (2) cycle();
    chk("F_to_cnt", to_seen, 0);
    chk("F_fe_cnt", fe_seen, 1);

    // Asynchronous reset in the middle of BUSY
    req_v = 3'b010;
    repeat (3) cycle();
    #2 rst = 1'b1;
    #1 chk_all_zero("E_async");
    m_owner = -1; m_rel = 1'b0; m_to = 1'b0; m_ptr = 0;
    @(negedge clk);
    model_check();
    rst = 1'b0;

    // Simultaneous requests after reset: rotation starts from requester 0
    clr();
    req_v = 3'b011;
    done = 1'b1;
    repeat (10) cycle();
    done = 1'b0;
    chk("B_launches", launch_log.size(), 2);
    if (launch_log.size() >= 2) begin
      chk("B_first", launch_log[0], 0);
      chk("B_second", launch_log[1], 1);
      chk("B_gap", launch_cyc[1] - launch_cyc[0], 4);
    end

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_v[k] && $urandom_range(3) == 0) begin
          req_v[k]   = 1'b1;
          req_msg[k] = W'($urandom);
        end else if ($urandom_range(7) == 0) begin
          req_msg[k] = W'($urandom);
        end
        if (req_v[k] && m_owner == k && m_age > 0 && $urandom_range(40) == 0) req_v[k] = 1'b0;
      end
      done  = ($urandom_range(5) == 0);
      flush = ($urandom_range(40) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sb_tx_arbiter.md
SB_TX_ARBITER -- requirements
Module: sb_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of sideband message requesters, e.g. the REPAIRCLK TX and RX sequencers.
REQ-002 Parameter SB_MSG_Width, default 4: width of one encoded sideband message.
REQ-003 Parameter TIMEOUT_CYC, default 255: maximum number of BUSY cycles before the arbiter forces release.
REQ-004 i_clk  in  1  single clock for the block.
REQ-005 i_rst  in  1  reset, asynchronous and active-high.
REQ-006 i_msg_valid  in  NUM_REQ  per-requester level request; held high until that requester sees its falling-edge pulse.
REQ-007 i_encoded_sb_msg  in  NUM_REQ*SB_MSG_Width  per-requester message; slice k belongs to requester k.
REQ-008 i_sb_done  in  1  one-cycle pulse from the sideband serializer: the current message is fully sent.
REQ-009 i_flush  in  1  synchronous abort of any transaction.
REQ-010 o_sb_msg  out  SB_MSG_Width  message forwarded to the serializer.
REQ-011 o_sb_msg_valid  out  1  one-cycle launch strobe to the serializer.
REQ-012 o_grant  out  NUM_REQ  one-hot owner of the transaction in flight, or 0.
REQ-013 o_sb_busy  out  1  shared busy; high from grant until release.
REQ-014 o_falling_edge_busy  out  NUM_REQ  one-cycle completion pulse, sent only to the granted requester.
REQ-015 o_timeout  out  1  one-cycle pulse when TIMEOUT_CYC expires.

Function
REQ-016 The block SHALL implement the states IDLE, GRANT, BUSY and RELEASE.
REQ-017 IDLE: if any i_msg_valid is high, the block SHALL pick a winner by round-robin starting at pointer rr_ptr, latch the winner's message and index, and go to GRANT.
REQ-018 GRANT: the block SHALL hold o_sb_msg_valid=1 for exactly one cycle with o_sb_msg equal to the latched message, then go to BUSY.
REQ-019 o_sb_busy and o_grant SHALL be high in GRANT and BUSY, and low in IDLE and RELEASE.
REQ-020 BUSY: a 1-cycle i_sb_done SHALL move the block to RELEASE; a cycle counter SHALL run and, on reaching TIMEOUT_CYC, SHALL move the block to RELEASE and pulse o_timeout.
REQ-021 RELEASE: the block SHALL assert o_falling_edge_busy[winner] for one cycle, set rr_ptr=(winner+1) mod NUM_REQ, grant nothing, and return to IDLE.
REQ-022 The one-cycle RELEASE gap lets the winner's registered valid drop; the block SHALL NOT re-grant in that cycle.
REQ-023 Latency: a request arriving in IDLE SHALL produce o_sb_msg_valid 1 cycle later (GRANT is the cycle after the request is sampled).
REQ-024 Requests that arrive simultaneously SHALL be resolved by rr_ptr only; requests that lose SHALL stay pending and be served in rotation.
REQ-025 If the winner drops i_msg_valid during BUSY, the transaction SHALL still complete and release normally.
REQ-026 Changes to i_encoded_sb_msg after the grant SHALL be ignored, because the message is latched.
REQ-027 An i_sb_done pulse outside BUSY SHALL be ignored.
REQ-028 i_flush, in any state, SHALL force IDLE on the next cycle with busy, grant and strobes low and no falling-edge pulse; rr_ptr SHALL be unchanged.
REQ-029 i_flush SHALL take priority over i_sb_done and the timeout in the same cycle.
REQ-030 If i_sb_done and timer expiry occur in the same cycle, i_sb_done SHALL win and o_timeout SHALL stay 0.
REQ-031 The timeout counter SHALL be $clog2(TIMEOUT_CYC+1) bits wide, cleared on entry to GRANT, and SHALL saturate rather than wrap.

Reset
REQ-032 While i_rst=1, the block SHALL be in IDLE with rr_ptr=0 and the counter=0.
REQ-033 While i_rst=1, every output SHALL be 0.
REQ-034 Reset asserted mid-transaction SHALL abort with no falling-edge pulse.
REQ-035 All outputs SHALL be registered.

Structure
REQ-036 The state enum and the sideband message encodings (init/result/done req/resp) SHALL live in the shared package mbinit_pkg.
REQ-037 Round-robin selection SHALL be a separate sub-module, rr_picker: inputs are the request vector and the pointer; outputs are a one-hot grant and the index.

Verification
REQ-038 Single request: req0 msg=4'b0001 with i_sb_done 5 cycles after launch -> o_sb_msg_valid for 1 cycle with 0001, busy for 6 cycles, o_falling_edge_busy=2'b01 for 1 cycle, then IDLE.
REQ-039 Simultaneous request: req0 and req1 both held with rr_ptr=0 -> req0 served first, then one RELEASE gap, then req1 served; req1 never sees the falling-edge pulse of req0.
REQ-040 Timeout: TIMEOUT_CYC=8 and no i_sb_done -> o_timeout pulses 8 cycles after GRANT together with the falling-edge pulse to the winner.
REQ-041 Flush in BUSY: i_flush 3 cycles into BUSY -> IDLE next cycle, no falling-edge pulse, rr_ptr unchanged.
REQ-042 Reset mid-BUSY: i_rst pulsed asynchronously -> all outputs 0 immediately; afterwards a new request is served normally from rr_ptr=0.
REQ-043 Race: i_sb_done in the same cycle as counter expiry -> o_timeout=0 and normal release.
